// File: rtl/i_buf_rx_pkg.sv
// Shared definitions for the i_buf_rx_deser receive path.
//   rx_state_e : deserialiser FSM states
//   DEF_*      : default word / filter-length widths
//   bit_cnt_w  : bit-counter width, clog2(data_w + 2), which leaves room
//                for the optional parity bit (I_BUF_RX_PARITY_EN).
package i_buf_rx_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_FILT_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  function automatic int unsigned bit_cnt_w(input int unsigned data_w);
    int unsigned n;
    int unsigned w;
    n = data_w + 2;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/i_buf_rx_filt.sv
// One receive pad path: I_BUF (behavioural model, EN gates the pad), then
// optional inversion, a 2-flop synchroniser and a glitch filter, followed by
// edge detection on the filtered level.
//   clk, rst_n  : core clock, asynchronous active-low reset
//   pad_i       : raw pad input
//   en_i        : I_BUF enable; a disabled buffer reads as 0 before inversion
//   filt_len_i  : filtered level follows the synced value only after it has
//                 differed for filt_len_i+1 consecutive cycles
//   level_o     : filtered level (resets to 0 regardless of INVERT)
//   rise_o/fall_o : single-cycle edges of level_o
module i_buf_rx_filt #(
  parameter int unsigned FILT_W = 4,
  parameter bit          INVERT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad_i,
  input  logic              en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              level_o,
  output logic              rise_o,
  output logic              fall_o
);

  logic              buf_o;
  logic              pol;
  logic              sync_q1;
  logic              sync_q2;
  logic              level_d1;
  logic [FILT_W-1:0] cnt_q;

  assign buf_o = en_i & pad_i;
  assign pol   = INVERT ? ~buf_o : buf_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      level_o  <= 1'b0;
      level_d1 <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q1  <= pol;
      sync_q2  <= sync_q1;
      level_d1 <= level_o;
      if (sync_q2 == level_o) begin
        cnt_q <= '0;
      end else if (cnt_q >= filt_len_i) begin
        // >= rather than == so a shortened filt_len_i mid-count cannot wrap
        level_o <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = level_o & ~level_d1;
  assign fall_o = ~level_o & level_d1;

endmodule

// File: rtl/i_buf_rx_deser.sv
// Framed serial receiver, counterpart of the inverting tristate pad driver.
// Data, strobe and frame pads each pass through i_buf_rx_filt; words are
// shifted in MSB-first on filtered strobe rises while the frame is high and
// presented on a valid/ready output register.
//   clk, rst_n    : core clock, asynchronous active-low reset
//   data_i        : serial data pad
//   strb_i        : strobe pad, bit sampled on filtered rising edge
//   ctrl_T        : frame pad, filtered level high = frame active
//   en_i          : receiver enable (I_BUF EN); low forces the FSM idle
//   filt_len_i    : glitch-filter length
//   out_data_o    : received word
//   out_valid_o   : word available
//   out_ready_i   : consumer accepts word
//   frame_err_o   : 1-cycle pulse, frame ended mid-word
//   overrun_o     : 1-cycle pulse, completed word dropped (output full)
//   par_err_o     : 1-cycle pulse, parity mismatch (I_BUF_RX_PARITY_EN only)
// Build option I_BUF_RX_PARITY_EN: an even-parity bit follows each DATA_W
// data bits; words failing parity are discarded.
module i_buf_rx_deser
  import i_buf_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FILT_W = DEF_FILT_W,
  parameter bit          INVERT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_i,
  input  logic              strb_i,
  input  logic              ctrl_T,
  input  logic              en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              frame_err_o,
`ifdef I_BUF_RX_PARITY_EN
  output logic              par_err_o,
`endif
  output logic              overrun_o
);

  localparam int unsigned CNT_W = bit_cnt_w(DATA_W);
`ifdef I_BUF_RX_PARITY_EN
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
`else
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
`endif

  logic data_level;
  logic data_rise_unused;
  logic data_fall_unused;
  logic strb_rise;
  logic strb_level_unused;
  logic strb_fall_unused;
  logic frame_level;
  logic frame_rise;
  logic frame_fall;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] word_data;
  logic              word_done;
  logic              frame_err_d;
`ifdef I_BUF_RX_PARITY_EN
  logic              par_err_d;
`endif

  i_buf_rx_filt #(.FILT_W(FILT_W), .INVERT(INVERT)) u_filt_data (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_i      (data_i),
    .en_i       (en_i),
    .filt_len_i (filt_len_i),
    .level_o    (data_level),
    .rise_o     (data_rise_unused),
    .fall_o     (data_fall_unused)
  );

  i_buf_rx_filt #(.FILT_W(FILT_W), .INVERT(INVERT)) u_filt_strb (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_i      (strb_i),
    .en_i       (en_i),
    .filt_len_i (filt_len_i),
    .level_o    (strb_level_unused),
    .rise_o     (strb_rise),
    .fall_o     (strb_fall_unused)
  );

  i_buf_rx_filt #(.FILT_W(FILT_W), .INVERT(INVERT)) u_filt_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_i      (ctrl_T),
    .en_i       (en_i),
    .filt_len_i (filt_len_i),
    .level_o    (frame_level),
    .rise_o     (frame_rise),
    .fall_o     (frame_fall)
  );

  // word_done marks a completed word that is eligible for the output
  // register; a parity failure completes the word but never raises it.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    word_data   = shreg_q;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
`ifdef I_BUF_RX_PARITY_EN
    par_err_d   = 1'b0;
`endif
    if (!en_i) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_rise) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end
        end
        ST_SHIFT: begin
          // frame fall wins over a coincident strobe rise
          if (frame_fall) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            frame_err_d = (bit_cnt_q != '0);
          end else if (strb_rise && frame_level) begin
`ifdef I_BUF_RX_PARITY_EN
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              word_data = shreg_q;
              word_done = ~(^shreg_q ^ data_level);
              par_err_d = ^shreg_q ^ data_level;
            end else begin
              shreg_d   = {shreg_q[DATA_W-2:0], data_level};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
`else
            shreg_d   = {shreg_q[DATA_W-2:0], data_level};
            word_data = shreg_d;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              word_done = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef I_BUF_RX_PARITY_EN
      par_err_o   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_o <= frame_err_d;
      overrun_o   <= word_done & out_valid_o & ~out_ready_i;
`ifdef I_BUF_RX_PARITY_EN
      par_err_o   <= par_err_d;
`endif
      if (word_done && (!out_valid_o || out_ready_i)) begin
        out_data_o  <= word_data;
        out_valid_o <= 1'b1;
      end else if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i_buf_rx_deser.md
Name: i_buf_rx_deser

Overview:
- Receive-side counterpart of the team's inverting tristate pad driver.
- Captures three pads through I_BUF primitives, each with optional inversion: serial data, source strobe, frame/control.
- Synchronises, glitch-filters and edge-detects each pad, then deserialises framed words MSB-first.
- Presents each word on a valid/ready output register to core logic.

Parameters:
DATA_W, 8, bits per word
FILT_W, 4, width of the glitch-filter length field and counter
INVERT, 1, 1 = pad polarity inverted after I_BUF (matches the inverting driver); 0 = true polarity

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
data_i  input  1  serial data pad
strb_i  input  1  source strobe pad; bit sampled on filtered rising edge
ctrl_T  input  1  frame pad; filtered level high = frame active
en_i  input  1  receiver enable; drives I_BUF EN
filt_len_i  input  FILT_W  glitch-filter length
out_data_o  output  DATA_W  received word
out_valid_o  output  1  word available
out_ready_i  input  1  consumer accepts word
frame_err_o  output  1  one-cycle pulse: frame ended mid-word
overrun_o  output  1  one-cycle pulse: word dropped, output still full

Behaviour:
- Reset: all flops 0, including sync, filter, state, bit_cnt, out_data_o, out_valid_o, frame_err_o and overrun_o. Filtered levels reset to 0 regardless of INVERT.
- Pad path, per pad: I_BUF(I=pad, EN=en_i), then optional inversion, then a 2-flop synchroniser, then the glitch filter.
- Glitch filter: the filtered level changes only after the synced value has differed from it for filt_len_i+1 consecutive cycles. The counter clears on any cycle where synced equals filtered. filt_len_i=0 means a 1-cycle filter.
- Edge detect: rise = filtered & ~filtered_d1.
- Latency: pad change to filtered level = 2 + filt_len_i + 1 cycles.
- FSM IDLE:
  - frame rise → SHIFT, bit_cnt = 0, shift register = 0.
- FSM SHIFT:
  - Each strobe rise while frame filtered high: shreg = {shreg[DATA_W-2:0], data}, bit_cnt++.
  - bit_cnt reaches DATA_W: word completes. bit_cnt returns to 0 and the FSM stays in SHIFT (streaming while frame stays high).
  - Frame fall with bit_cnt = 0: → IDLE, clean end, no error.
  - Frame fall with bit_cnt ≠ 0: → IDLE, frame_err_o pulses 1 cycle, partial word discarded.
- Same-cycle strobe rise and frame fall: the strobe edge is ignored and the frame fall is handled.
- Data is sampled at the filtered strobe edge. Data must be stable for ≥ filt_len_i+3 cycles around the strobe edge.
- Output register:
  - On word completion with out_valid_o = 0 (or being popped that cycle), load out_data_o and set out_valid_o the next cycle.
  - Word completion with out_valid_o = 1 and out_ready_i = 0: new word dropped, old word held, overrun_o pulses.
  - out_valid_o & out_ready_i clears out_valid_o unless a new word loads in the same cycle, in which case valid stays 1 with the new data.
  - out_data_o is stable while out_valid_o = 1 and not accepted.
- en_i low:
  - FSM forced to IDLE and bit_cnt cleared, no error pulse.
  - Filtered levels and edges are ignored.
  - Output register and handshake keep operating.
- Reset mid-word: immediate clear; no pulses after release.

Optional Feature:
- Macro: I_BUF_RX_PARITY_EN.
- With the macro defined:
  - One extra even-parity bit follows each DATA_W bits.
  - bit_cnt counts to DATA_W+1.
  - Added port par_err_o output 1 pulses on mismatch; the word is discarded and not loaded.
  - A frame fall after data bits but before the parity bit counts as a frame error.
- Without the macro: no parity bit, no par_err_o port, words complete at DATA_W bits.

Decomposition:
- Package i_buf_rx_pkg:
  - state enum (IDLE, SHIFT)
  - default DATA_W / FILT_W localparams
  - bit-counter width function clog2(DATA_W+2)
- Sub-module i_buf_rx_filt: I_BUF + inversion + 2-flop sync + glitch filter + rise/fall outputs, instantiated three times.

Test Plan:
- Reset, INVERT=1, filt_len=2: all pads driven high → filtered levels 0. Frame pad low (active) with 8 strobes, data bits 1,0,1,0,0,1,0,1 sent as pad levels inverted → out_data_o=8'hA5, valid one cycle after the 8th strobe edge detect; ready=1 → valid clears next cycle.
- Glitch: filt_len=3, 3-cycle pulse on strobe pad → no shift; 4-cycle pulse (after sync) → exactly one bit shifted.
- Streaming: frame held for 16 strobes sending 8'h3C then 8'hC3 with ready=0 → first word held as 3C, overrun_o pulses once, out_data_o stays 8'h3C.
- Frame error: frame drops after 5 bits → frame_err_o one pulse, valid stays 0. Next full frame with 8'h81 → out_data_o=8'h81.
- en_i deasserted after 3 bits, reasserted, new 8-bit frame sending 8'h5A → out_data_o=8'h5A, no frame_err_o.
- With I_BUF_RX_PARITY_EN: word 8'h07 with parity 1 → accepted; parity 0 → par_err_o pulse, out_valid_o stays 0.
